// File: rtl/arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating 4-bit fetch-starvation counter; only present when
// ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != 4'hF)) begin
      count <= count + 4'd1;
    end
  end

  assign hit = (count == 4'(LIMIT));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port sync-read RAM between fetch and data ports.
// Optional fetch-starvation guard enabled by ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned SIZE         = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IF_REQ,
  input  logic [ADDR_WIDTH-1:0] IF_ADDR,
  output logic                  IF_GNT,
  output logic                  IF_RVALID,
  output logic [SIZE-1:0]       IF_RDATA,
  input  logic                  D_REQ,
  input  logic                  D_WE,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic [SIZE-1:0]       D_WDATA,
  output logic                  D_GNT,
  output logic                  D_RVALID,
  output logic [SIZE-1:0]       D_RDATA,
  output logic                  MEM_EN,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [SIZE-1:0]       MEM_WDATA,
  input  logic [SIZE-1:0]       MEM_Q
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic   force_if;
  logic   if_gnt;
  logic   d_gnt;
  owner_t resp_owner;
  owner_t owner_next;

`ifdef ARB_STARVE_GUARD_EN
  logic starve_hit;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk     (CLK),
    .reset_n (RESET_N),
    .inc     (IF_REQ & D_REQ & d_gnt),
    .clr     (if_gnt | ~IF_REQ),
    .hit     (starve_hit)
  );

  assign force_if = starve_hit & IF_REQ;
`else
  assign force_if = 1'b0;
`endif

  // Grants are gated by RESET_N so every strobe reads 0 while reset is held.
  assign d_gnt  = RESET_N & D_REQ & ~force_if;
  assign if_gnt = RESET_N & IF_REQ & ~d_gnt;

  assign IF_GNT = if_gnt;
  assign D_GNT  = d_gnt;
  assign MEM_EN = if_gnt | d_gnt;
  assign MEM_WE = d_gnt & D_WE;

  always_comb begin
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (d_gnt) begin
      MEM_ADDR  = D_ADDR;
      MEM_WDATA = D_WDATA;
    end else if (if_gnt) begin
      MEM_ADDR  = IF_ADDR;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt) begin
      owner_next = OWN_IF;
    end else if (d_gnt && !D_WE) begin
      owner_next = OWN_D;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      resp_owner <= OWN_NONE;
    end else begin
      resp_owner <= owner_next;
    end
  end

  assign IF_RVALID = (resp_owner == OWN_IF);
  assign D_RVALID  = (resp_owner == OWN_D);
  assign IF_RDATA  = RESET_N ? MEM_Q : '0;
  assign D_RDATA   = RESET_N ? MEM_Q : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, synchronous-read memory between the core's instruction-fetch port and its data load/store port, so that program and data live in one unified RAM. It sits between the core and the memory, in the positions the core's ROM and RAM ports occupy today. It grants one access per cycle, routes the read data back to the requester that issued the read, and supports back-to-back accesses with no bubble. Data accesses take priority over fetches; an optional guard bounds how long a fetch can be starved.

## Interface
- SIZE, 32, data width in bits
- ADDR_WIDTH, 10, word-address width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before a forced fetch grant (guard build only); legal range 1..15
- CLK  in  1  clock, rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- IF_REQ  in  1  fetch request, held until granted
- IF_ADDR  in  ADDR_WIDTH  fetch word address
- IF_GNT  out  1  fetch accepted this cycle
- IF_RVALID  out  1  IF_RDATA valid
- IF_RDATA  out  SIZE  fetched instruction
- D_REQ  in  1  data request, held until granted
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  ADDR_WIDTH  data word address
- D_WDATA  in  SIZE  store data
- D_GNT  out  1  data access accepted this cycle
- D_RVALID  out  1  D_RDATA valid
- D_RDATA  out  SIZE  load data
- MEM_EN  out  1  memory access this cycle
- MEM_WE  out  1  memory write strobe
- MEM_ADDR  out  ADDR_WIDTH  memory word address
- MEM_WDATA  out  SIZE  memory write data
- MEM_Q  in  SIZE  memory read data, valid the cycle after a read with MEM_EN=1

## Operation
- Grant logic is combinational from the REQ inputs and the guard state. At most one GNT is high per cycle.
- Without a forced fetch, D_REQ wins. IF_GNT = IF_REQ & ~D_REQ.
- MEM_EN = IF_GNT | D_GNT. MEM_ADDR, MEM_WE and MEM_WDATA come from the granted port.
- MEM_WE = D_GNT & D_WE. Fetch never writes.
- When no port is granted, MEM_ADDR = 0, MEM_WE = 0 and MEM_WDATA = 0.
- Response owner register resp_owner ∈ {OWN_NONE, OWN_IF, OWN_D}:
  - next = OWN_IF on an IF grant;
  - OWN_D on a load grant;
  - OWN_NONE on a store grant or no grant.
- IF_RVALID = (resp_owner == OWN_IF). D_RVALID = (resp_owner == OWN_D).
- IF_RDATA and D_RDATA both carry MEM_Q; they are meaningful only while the matching RVALID is high.
- Stores produce no RVALID.
- A request dropped before its grant is legal and has no effect.
- A new grant may be issued in the same cycle an earlier read's response is returned.

## Timing
- Grant latency is 0 cycles: GNT is asserted in the same cycle as REQ when the port wins.
- Read response latency is exactly 1 cycle after GNT.
- Store completes at the clock edge at the end of its GNT cycle.
- Sustained throughput is 1 access per cycle across both ports.
- While RESET_N is low:
  - resp_owner = OWN_NONE;
  - starvation counter = 0;
  - every GNT, MEM_EN, MEM_WE and RVALID output is forced to 0;
  - MEM_ADDR, MEM_WDATA and both RDATA outputs are 0.
- Reset asserted while a read is outstanding drops that read. No RVALID appears after reset is released.

## Configuration
- ARB_STARVE_GUARD_EN defined: a 4-bit counter tracks fetch starvation.
  - Increments each cycle in which IF_REQ & D_REQ & D_GNT.
  - Clears on IF_GNT or when IF_REQ is low.
  - When the counter equals STARVE_LIMIT, the fetch is forced: IF_GNT = IF_REQ, D_GNT = 0, and the counter clears.
- Not defined: strict data priority; no counter is built; a fetch may starve indefinitely.

## Structure
- Package arb_pkg holds the owner_t enum (OWN_NONE, OWN_IF, OWN_D) and the default STARVE_LIMIT constant.
- One sub-module, starve_counter: saturating 4-bit counter with inc, clr and a hit-at-limit output. It is instantiated only under ARB_STARVE_GUARD_EN.
- The rest of the block (grant logic, output muxing, resp_owner register) lives in mem_port_arbiter.

## Test plan
- Fetch-only reads:
  - Stimulus: IF_REQ=1 with IF_ADDR = 0, 1, 2 on consecutive cycles; no D_REQ.
  - Response: IF_GNT high in each of those cycles; IF_RVALID high on the three following cycles; IF_RDATA = mem[0], mem[1], mem[2].
- Conflict:
  - Stimulus: IF_REQ=1 with IF_ADDR=5 and D_REQ=1, D_WE=0, D_ADDR=9 in the same cycle.
  - Response: D_GNT=1, IF_GNT=0. Next cycle D_RVALID=1 with D_RDATA=mem[9]; the fetch is granted that cycle if D_REQ is low.
- Store then load:
  - Stimulus: store D_ADDR=3, D_WDATA=32'hDEADBEEF, then load D_ADDR=3.
  - Response: no RVALID after the store; D_RDATA=32'hDEADBEEF one cycle after the load grant.
- Starvation, guard build, STARVE_LIMIT=4:
  - Stimulus: D_REQ and IF_REQ held high continuously.
  - Response: data is granted for 4 cycles, fetch in the 5th, and the pattern repeats.
  - Without the macro: the fetch is never granted.
- Reset mid-read:
  - Stimulus: assert RESET_N low in the cycle after an IF grant.
  - Response: IF_RVALID=0 immediately and after release; all outputs 0 during reset.
